sif_wa_sink: RTL and testbench
==============================

# sif_wa_sink

Downstream consumer of the SIF write-address (WA) port. It captures every `wa_wr_s` strobe with its `wa_addr`/`wa_data_wr` into a FIFO, then drains the entries one at a time to a backing memory port over a req/gnt handshake. It sits between the SIF block and the register/memory target and absorbs bursts of WA writes while the target stalls. Level, full/empty and overflow status are exported.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `AW`, 16: address width; matches `wa_addr`.
- `DW`, 16: data width; matches `wa_data_wr`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wa_wr_s`  in  1  write strobe from SIF; one write per high cycle.
- `wa_addr`  in  AW  write address, valid when `wa_wr_s`=1.
- `wa_data_wr`  in  DW  write data, valid when `wa_wr_s`=1.
- `mem_req`  out  1  drain request to memory.
- `mem_gnt`  in  1  memory accepts the current request.
- `mem_addr`  out  AW  address of head entry.
- `mem_wdata`  out  DW  data of head entry.
- `fifo_level`  out  $clog2(DEPTH+1)  occupied entries.
- `fifo_full`  out  1  level == DEPTH.
- `fifo_empty`  out  1  level == 0.
- `ovf_cnt`  out  8  dropped-write counter, saturates at 255.
- `ovf_clr`  in  1  clears `ovf_cnt` next cycle.

## Operation
- Push: `wa_wr_s`=1 and (not full, or pop in the same cycle) → entry written at tail; level +1 (net 0 if pop coincides).
- Drop: `wa_wr_s`=1, full, no pop → write discarded, `ovf_cnt` +1 (saturating). If `ovf_clr` is set in the same cycle, the clear wins and `ovf_cnt` = 0.
- Drain FSM states (in shared package):
  - IDLE: `mem_req`=0. Moves to REQ when `fifo_empty`=0.
  - REQ: `mem_req`=1, with `mem_addr`/`mem_wdata` = head entry, held stable until grant.
    - `mem_gnt`=1 → pop the head. Stay in REQ if level after the pop > 0, otherwise go to IDLE.
    - `mem_gnt` is ignored in IDLE.
- Simultaneous push + pop: level unchanged. Push into an empty FIFO with no pop: level 1.
- Pointers are log2(DEPTH) bits and wrap naturally. Level is tracked separately to distinguish full from empty.
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0, `ovf_cnt`=0, FSM=IDLE, pointers=0. FIFO storage is not reset.
- Reset mid-operation: pending entries are discarded, and `mem_req` drops on the cycle after `rst_n` is sampled low.

## Timing
- Push-to-request latency: a write at edge N gives `mem_req`=1 with that entry after edge N+1, when the FIFO was empty and the FSM was in IDLE.
- Back-to-back grants: one entry drained per cycle while `mem_gnt` is held high.
- All outputs are registered. There is no combinational path from `wa_*` or `mem_gnt` to any output.
- Status outputs reflect state after the current edge. `fifo_full` is asserted in the cycle following the push that fills the FIFO.

## Configuration
- `SIF_WA_COALESCE_EN`, when defined:
  - Merge condition: `wa_wr_s` with `wa_addr` equal to the tail (most recently pushed) entry's address.
  - Tail-safety condition: the tail entry is not the head being popped this cycle, i.e. level ≥ 2, or level = 1 with no grant.
  - When both conditions hold, the tail data is overwritten, level is unchanged, and no overflow is counted even when full.
- When `SIF_WA_COALESCE_EN` is undefined: every accepted write is pushed. There is no address compare logic.

## Structure
- Shared package `sif_pkg` holds:
  - `SIF_AW`, `SIF_DW` constants;
  - `wa_entry_t` packed struct {addr, data};
  - `wa_drain_state_e` enum {IDLE, REQ}.
- Sub-module `sif_wa_fifo` holds:
  - a parameterised storage array of `wa_entry_t`;
  - push/pop pointers, level, full and empty;
  - a tail-overwrite port used only under `SIF_WA_COALESCE_EN`.
- The top level holds the drain FSM, the overflow counter and the coalesce compare.

## Test plan
- Reset, then a single write addr=0x0010 data=0xBEEF, with `mem_gnt` tied 1 → `mem_req` high one cycle later with 0x0010/0xBEEF; level returns to 0; FSM back in IDLE.
- With `mem_gnt`=0, issue 9 writes (DEPTH=8) → `fifo_full`=1, `ovf_cnt`=1. Then raise `mem_gnt` → 8 entries drain in order on 8 consecutive cycles.
- Full FIFO with push and grant in the same cycle → push accepted, level stays 8, `ovf_cnt` unchanged.
- With `mem_gnt` toggling randomly, check that `mem_addr`/`mem_wdata` stay stable while `mem_req`=1 and `mem_gnt`=0.
- 300 writes while full with `mem_gnt`=0 → `ovf_cnt`=255. Assert `ovf_clr` together with a drop → `ovf_cnt`=0.
- With `SIF_WA_COALESCE_EN` and `mem_gnt`=0, write 0x20/0x1111 then 0x20/0x2222 → level 1; drain yields a single 0x20/0x2222. Without the macro → level 2 and both writes drain.

Source files
------------

// File: rtl/sif_pkg.sv
// Shared SIF types: write-address entry layout and drain FSM state encoding.
package sif_pkg;

    localparam int SIF_AW = 16;
    localparam int SIF_DW = 16;

    typedef struct packed {
        logic [SIF_AW-1:0] addr;
        logic [SIF_DW-1:0] data;
    } wa_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wa_drain_state_e;

endpackage

// File: rtl/sif_wa_fifo.sv
// WA entry FIFO with a registered head entry and a tail data-overwrite port.
// SIF_WA_COALESCE_EN additionally exposes the tail entry for address compare.
module sif_wa_fifo
    import sif_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wa_entry_t                    push_entry,
    input  logic                         pop,
    input  logic                         ow_en,
    input  logic [SIF_DW-1:0]            ow_data,
    output wa_entry_t                    head,
`ifdef SIF_WA_COALESCE_EN
    output wa_entry_t                    tail,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   level_nxt,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    wa_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_nxt;
    logic [PW-1:0]   tail_idx;
    logic            do_push;
    wa_entry_t       head_nxt;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

`ifdef SIF_WA_COALESCE_EN
    assign tail = mem[tail_idx];
`endif

    always_comb begin
        do_push    = push && (!full || pop);
        rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
        tail_idx   = wr_ptr - PW'(1);

        level_nxt = level;
        if (do_push && !pop)
            level_nxt = level + LW'(1);
        else if (!do_push && pop)
            level_nxt = level - LW'(1);

        // The head register must see a same-cycle write landing on the next head slot.
        head_nxt = mem[rd_ptr_nxt];
        if (do_push && (wr_ptr == rd_ptr_nxt))
            head_nxt = push_entry;
        else if (ow_en && (tail_idx == rd_ptr_nxt))
            head_nxt = '{addr: mem[tail_idx].addr, data: ow_data};
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_entry;
        else if (ow_en)
            mem[tail_idx].data <= ow_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            if (level_nxt != '0)
                head <= head_nxt;
        end
    end

endmodule

// File: rtl/sif_wa_sink.sv
// SIF write-address sink: buffers WA writes and drains them over a req/gnt port.
// Define SIF_WA_COALESCE_EN to merge repeated writes to the tail address.
module sif_wa_sink
    import sif_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wa_wr_s,
    input  logic [AW-1:0]                wa_addr,
    input  logic [DW-1:0]                wa_data_wr,
    output logic                         mem_req,
    input  logic                         mem_gnt,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [7:0]                   ovf_cnt,
    input  logic                         ovf_clr
);

    localparam int LW = $clog2(DEPTH+1);

    wa_drain_state_e  state;
    wa_drain_state_e  state_nxt;
    wa_entry_t        wr_entry;
    wa_entry_t        head;
    logic [LW-1:0]    level_nxt;
    logic             pop;
    logic             push;
    logic             merge;
    logic             drop;

    assign wr_entry  = '{addr: SIF_AW'(wa_addr), data: SIF_DW'(wa_data_wr)};
    assign pop       = (state == REQ) && mem_gnt;
    assign mem_req   = (state == REQ);
    assign mem_addr  = AW'(head.addr);
    assign mem_wdata = DW'(head.data);

`ifdef SIF_WA_COALESCE_EN
    wa_entry_t tail;
    // The tail may only be rewritten if it is not leaving as the head this cycle.
    assign merge = wa_wr_s && !fifo_empty && (wr_entry.addr == tail.addr) &&
                   ((fifo_level >= LW'(2)) || ((fifo_level == LW'(1)) && !pop));
`else
    assign merge = 1'b0;
`endif

    assign push = wa_wr_s && !merge;
    assign drop = push && fifo_full && !pop;

    sif_wa_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .ow_en      (merge),
        .ow_data    (wr_entry.data),
        .head       (head),
`ifdef SIF_WA_COALESCE_EN
        .tail       (tail),
`endif
        .level      (fifo_level),
        .level_nxt  (level_nxt),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!fifo_empty) state_nxt = REQ;
            REQ:  if (pop && (level_nxt == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_cnt <= '0;
        else if (ovf_clr)
            ovf_cnt <= '0;
        else if (drop && (ovf_cnt != 8'hFF))
            ovf_cnt <= ovf_cnt + 8'd1;
    end

endmodule

// File: tb/tb_sif_wa_sink.sv
// Scoreboard bench for sif_wa_sink: expected drains queued at stimulus, checked by a monitor.
module tb_sif_wa_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wa_wr_s;
    logic [15:0] wa_addr;
    logic [15:0] wa_data_wr;
    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  ovf_cnt;
    logic        ovf_clr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_drained = 0;
    bit          chk_stable = 1'b1;
    logic [31:0] sb [$];

    sif_wa_sink #(.DEPTH(8), .AW(16), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wa_wr_s    (wa_wr_s),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .ovf_cnt    (ovf_cnt),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write cycle; queued as an expected drain only when the caller says it is accepted.
    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit expect_drain);
        wa_wr_s    = 1'b1;
        wa_addr    = a;
        wa_data_wr = d;
        if (expect_drain) sb.push_back({a, d});
        tick();
        wa_wr_s = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int i = 0;
        while (!(fifo_empty && !mem_req) && i < 60) begin
            tick();
            i++;
        end
        chk(name, 32'(fifo_empty && !mem_req), 32'd1);
    endtask

    // Monitor: every accepted drain is popped from the scoreboard; held requests must stay stable.
    initial begin
        logic        prev_hold;
        logic [31:0] prev_ent;
        logic [31:0] exp_ent;
        prev_hold = 1'b0;
        prev_ent  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && prev_hold && chk_stable)
                chk("hold_stable", {mem_addr, mem_wdata}, prev_ent);
            if (rst_n && mem_req && mem_gnt) begin
                n_drained++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    exp_ent = sb.pop_front();
                    chk("drain_addr", 32'(mem_addr), 32'(exp_ent[31:16]));
                    chk("drain_data", 32'(mem_wdata), 32'(exp_ent[15:0]));
                end
            end
            prev_hold = rst_n && mem_req && !mem_gnt;
            prev_ent  = {mem_addr, mem_wdata};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        logic [19:0] gpat;
        int          k;
        rst_n = 1'b0; wa_wr_s = 1'b0; wa_addr = '0; wa_data_wr = '0;
        mem_gnt = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req",   32'(mem_req),    32'd0);
        chk("rst_addr",  32'(mem_addr),   32'd0);
        chk("rst_wdata", 32'(mem_wdata),  32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full",  32'(fifo_full),  32'd0);
        chk("rst_ovf",   32'(ovf_cnt),    32'd0);
        rst_n = 1'b1;
        tick();

        // Single write with grant tied high: request appears one edge after the write.
        mem_gnt = 1'b1;
        wr(16'h0010, 16'hBEEF, 1'b1);
        @(negedge clk);
        chk("t1_req_pre", 32'(mem_req), 32'd0);
        chk("t1_level1",  32'(fifo_level), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_req", 32'(mem_req), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_level0", 32'(fifo_level), 32'd0);
        chk("t1_idle",   32'(mem_req),    32'd0);
        tick();

        // Nine writes with grant low: one drop, then eight back-to-back drains.
        mem_gnt = 1'b0;
        for (int i = 0; i < 9; i++)
            wr(16'h0100 + 16'(i), 16'hA000 + 16'(i), i < 8);
        @(negedge clk);
        chk("t2_full",  32'(fifo_full),  32'd1);
        chk("t2_level", 32'(fifo_level), 32'd8);
        chk("t2_ovf",   32'(ovf_cnt),    32'd1);
        tick();
        mem_gnt = 1'b1;
        d0 = n_drained;
        repeat (8) tick();
        chk("t2_b2b_cnt", 32'(n_drained - d0), 32'd8);
        @(negedge clk);
        chk("t2_empty", 32'(fifo_empty), 32'd1);
        tick();

        // Full FIFO, push and grant in the same cycle.
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++)
            wr(16'h0200 + 16'(i), 16'hB000 + 16'(i), 1'b1);
        mem_gnt = 1'b1;
        wr(16'h0300, 16'hC0DE, 1'b1);
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("t3_level", 32'(fifo_level), 32'd8);
        chk("t3_full",  32'(fifo_full),  32'd1);
        chk("t3_ovf",   32'(ovf_cnt),    32'd1);
        tick();
        mem_gnt = 1'b1;
        wait_empty("t3_drain_done");

        // Irregular grant pattern while writing every other cycle.
        gpat = 20'b1011_0010_1100_0101_0011;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            mem_gnt = gpat[i];
            if ((i % 2 == 0) && k < 8) begin
                wr(16'h0400 + 16'(k), 16'h4000 + 16'(k * 3), 1'b1);
                k++;
            end else begin
                tick();
            end
        end
        mem_gnt = 1'b1;
        wait_empty("t4_drain_done");

        // Overflow saturation and clear-wins-over-drop.
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++)
            wr(16'h0500 + 16'(i), 16'h5000 + 16'(i), 1'b1);
        for (int i = 0; i < 300; i++)
            wr(16'h0600 + 16'(i), 16'h6000, 1'b0);
        @(negedge clk);
        chk("t5_ovf_sat", 32'(ovf_cnt),    32'd255);
        chk("t5_level",   32'(fifo_level), 32'd8);
        tick();
        ovf_clr = 1'b1;
        wr(16'h7000, 16'h7000, 1'b0);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("t5_ovf_clr", 32'(ovf_cnt), 32'd0);
        tick();
        wr(16'h7001, 16'h7001, 1'b0);
        @(negedge clk);
        chk("t5_ovf_inc", 32'(ovf_cnt), 32'd1);
        tick();
        mem_gnt = 1'b1;
        wait_empty("t5_drain_done");

        // Reset while entries are pending.
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++)
            wr(16'h0800 + 16'(i), 16'h8000 + 16'(i), 1'b1);
        tick();
        @(negedge clk);
        chk("t6_req_before", 32'(mem_req), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t6_req_after", 32'(mem_req),    32'd0);
        chk("t6_level",     32'(fifo_level), 32'd0);
        chk("t6_empty",     32'(fifo_empty), 32'd1);
        chk("t6_ovf",       32'(ovf_cnt),    32'd0);
        tick();

        // Repeated address to the tail entry.
`ifdef SIF_WA_COALESCE_EN
        chk_stable = 1'b0;
        wr(16'h0020, 16'h1111, 1'b0);
        wr(16'h0020, 16'h2222, 1'b1);
        @(negedge clk);
        chk("t7_level", 32'(fifo_level), 32'd1);
`else
        wr(16'h0020, 16'h1111, 1'b1);
        wr(16'h0020, 16'h2222, 1'b1);
        @(negedge clk);
        chk("t7_level", 32'(fifo_level), 32'd2);
`endif
        tick();
        mem_gnt = 1'b1;
        wait_empty("t7_drain_done");
        chk_stable = 1'b1;
        mem_gnt = 1'b0;
        repeat (2) tick();

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
